// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath control blocks.
package cnn_pkg;

  localparam int unsigned ARB_MAX_REQ = 64;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/encoder.sv
// One-hot to binary encoder; an all-zero input encodes to index 0.
module encoder #(
  parameter int unsigned RADIX = 16,
  parameter int unsigned W     = (RADIX > 1) ? $clog2(RADIX) : 1
) (
  input  logic [RADIX-1:0] onehot,
  output logic [W-1:0]     idx
);

  // OR of the indices of all set bits; exact for one-hot input.
  always_comb begin
    idx = '0;
    for (int i = 0; i < RADIX; i++) begin
      if (onehot[i]) idx = idx | W'(i);
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set candidate at or above ptr, wrapping mod N.
module rr_pick #(
  parameter int unsigned N  = 16,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] spread;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;

  // Rotating the doubled vector keeps the wrap exact for any N, not just powers of two.
  assign dbl    = {cand, cand};
  assign rot    = N'(dbl >> ptr);
  assign first  = rot & (~rot + N'(1));
  assign spread = {{N{1'b0}}, first} << ptr;
  assign sel    = spread[N-1:0] | spread[2*N-1:N];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, binary index and valid/ready handshake.
module rr_arbiter
  import cnn_pkg::*;
#(
  parameter int unsigned NUM_REQ = 16,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] req_ack,
  output logic               gnt_valid,
  input  logic               gnt_ready,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx
);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
    $error("rr_arbiter: NUM_REQ out of range");
  end

  arb_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_inc;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick;
  logic               accept;

  assign accept    = (state == ARB_HOLD) && gnt_ready;
  assign gnt_valid = (state == ARB_HOLD);
  assign req_ack   = accept ? gnt_onehot : '0;

  // On accept the pointer moves past the winner and the winner is masked for the same-cycle pick.
  assign ptr_inc  = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  assign pick_ptr = accept ? ptr_inc : ptr;
  assign cand     = req & ~(accept ? gnt_onehot : '0);

  rr_pick #(
    .N  (NUM_REQ),
    .PW (IDX_W)
  ) u_pick (
    .cand (cand),
    .ptr  (pick_ptr),
    .sel  (pick)
  );

  encoder #(
    .RADIX (NUM_REQ),
    .W     (IDX_W)
  ) u_enc (
    .onehot (gnt_onehot),
    .idx    (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      ptr        <= '0;
      gnt_onehot <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|cand) begin
            gnt_onehot <= pick;
            state      <= ARB_HOLD;
          end
        end
        ARB_HOLD: begin
          // Grant is frozen until downstream takes it.
          if (gnt_ready) begin
            ptr <= ptr_inc;
            if (|cand) begin
              gnt_onehot <= pick;
            end else begin
              gnt_onehot <= '0;
              state      <= ARB_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter at NUM_REQ=16 and NUM_REQ=5.
module tb_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req16, ack16, oh16;
  logic        ready16, valid16;
  logic [3:0]  idx16;
  logic [4:0]  req5, ack5, oh5;
  logic        ready5, valid5;
  logic [2:0]  idx5;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(16), .IDX_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .req_ack(ack16), .gnt_valid(valid16),
    .gnt_ready(ready16), .gnt_onehot(oh16), .gnt_idx(idx16)
  );

  rr_arbiter #(.NUM_REQ(5), .IDX_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .req_ack(ack5), .gnt_valid(valid5),
    .gnt_ready(ready5), .gnt_onehot(oh5), .gnt_idx(idx5)
  );

  typedef struct {
    int          inst;
    logic        v;
    logic [63:0] oh;
    int          idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_v[2];
  int   m_idx[2];
  int   m_ptr[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_next(input logic [63:0] cand, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      if (cand[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  function automatic logic onehot0(input logic [63:0] x);
    return (x & (x - 64'd1)) == 64'd0;
  endfunction

  // Advance the reference model by one clock and queue the outputs it predicts.
  task automatic model_step(input int i, input int n, input logic [63:0] r, input logic rdy);
    logic [63:0] cand = r;
    logic        acc  = (m_v[i] != 0) && rdy;
    int          j;
    if (acc) begin
      m_ptr[i] = (m_idx[i] + 1) % n;
      cand     = cand & ~(64'd1 << m_idx[i]);
    end
    if (m_v[i] == 0 || acc) begin
      j = find_next(cand, m_ptr[i], n);
      m_v[i]   = (j >= 0) ? 1 : 0;
      m_idx[i] = (j >= 0) ? j : 0;
    end
    exp_q.push_back('{i, m_v[i] != 0, (m_v[i] != 0) ? (64'd1 << m_idx[i]) : 64'd0, m_idx[i]});
  endtask

  // Called at posedge+1: drive, check combinational ack, clock once, compare registered outputs.
  task automatic cycle(input logic [15:0] r16, input logic rdy16, input logic [4:0] r5, input logic rdy5);
    exp_t e;
    req16 = r16; ready16 = rdy16; req5 = r5; ready5 = rdy5;
    #1;
    check("ack16", ack16, (m_v[0] != 0 && rdy16) ? (64'd1 << m_idx[0]) : 64'd0);
    check("ack5", ack5, (m_v[1] != 0 && rdy5) ? (64'd1 << m_idx[1]) : 64'd0);
    check("ack16_onehot", onehot0(64'(ack16)), 1);
    model_step(0, 16, 64'(r16), rdy16);
    model_step(1, 5, 64'(r5), rdy5);
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.inst == 0) begin
        check("valid16", valid16, e.v);
        check("onehot16", oh16, e.oh);
        check("idx16", idx16, e.idx);
        check("inv16", valid16, |oh16);
      end else begin
        check("valid5", valid5, e.v);
        check("onehot5", oh5, e.oh);
        check("idx5", idx5, e.idx);
        check("inv5", valid5, |oh5);
      end
    end
    check("gnt16_onehot", onehot0(64'(oh16)), 1);
  endtask

  task automatic c16(input logic [15:0] r, input logic rdy);
    cycle(r, rdy, 5'd0, 1'b0);
  endtask

  task automatic c5(input logic [4:0] r, input logic rdy);
    cycle(16'd0, 1'b0, r, rdy);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid16"}, valid16, 0);
    check({tag, "_oh16"}, oh16, 0);
    check({tag, "_idx16"}, idx16, 0);
    check({tag, "_ack16"}, ack16, 0);
    check({tag, "_valid5"}, valid5, 0);
    check({tag, "_oh5"}, oh5, 0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0; m_idx[i] = 0; m_ptr[i] = 0;
    end
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    req16 = '0; ready16 = 1'b0; req5 = '0; ready5 = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;

    // Single request, accepted on the first presented cycle.
    c16(16'h0020, 1'b1);
    check("single_idx", idx16, 5);
    c16(16'h0020, 1'b1);
    c16(16'h0000, 1'b1);
    check("single_idle", valid16, 0);

    // Hold a grant on 3, then reset asynchronously mid-cycle.
    c16(16'h0008, 1'b0);
    c16(16'h0008, 1'b0);
    check("pre_rst_oh", oh16, 16'h0008);
    ready16 = 1'b1;
    rst_n   = 1'b0;
    #1;
    check_zero("async_rst");
    clear_model();
    req16 = '0; ready16 = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full load: 0..15,0,1 on consecutive cycles.
    for (int k = 1; k <= 18; k++) begin
      c16(16'hFFFF, 1'b1);
      check("full_seq", idx16, (k - 1) % 16);
    end
    c16(16'h0000, 1'b1);

    // Backpressure: grant 3 held four cycles, then 9.
    for (int k = 0; k < 4; k++) begin
      c16(16'h0208, 1'b0);
      check("bp_hold", idx16, 3);
    end
    c16(16'h0208, 1'b1);
    check("bp_next", idx16, 9);
    c16(16'h0200, 1'b1);

    // Late higher-priority requests do not preempt a held grant.
    c16(16'h0080, 1'b0);
    c16(16'h00FF, 1'b0);
    c16(16'h00FF, 1'b0);
    check("late_hold", idx16, 7);
    c16(16'h00FF, 1'b1);
    check("late_wrap", idx16, 0);
    c16(16'h0000, 1'b1);
    c16(16'h0080, 1'b0);
    c16(16'h017F, 1'b0);
    check("late_hold2", idx16, 7);
    c16(16'h01FF, 1'b1);
    check("late_next8", idx16, 8);
    c16(16'h0000, 1'b1);

    // Non-power-of-two wrap at NUM_REQ=5.
    c5(5'b10000, 1'b1);
    check("w5_first", idx5, 4);
    c5(5'b10010, 1'b1);
    check("w5_wrap", idx5, 1);
    c5(5'b10010, 1'b1);
    check("w5_again", idx5, 4);
    c5(5'b00000, 1'b1);

    // Random traffic on both instances against the model.
    for (int k = 0; k < 400; k++) begin
      cycle(16'($urandom), 1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
